// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC128S022 SPI responder.
// Frame is 16 bits: 4 leading zeros then a 12-bit sample, MSB first.
package adc_pkg;

    localparam int ADC_CHANNELS     = 8;
    localparam int ADC_RES          = 12;
    localparam int ADC_FRAME_BITS   = 16;
    localparam int ADC_ADDR_LSB_CNT = 4;

    typedef logic [ADC_RES-1:0] adc_sample_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } adc_resp_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with one-clk rise/fall strobes.
// Level lags the pin by SYNC_STAGES clk; the strobes are valid in the same clk as the new level.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic n_reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to the pin's idle level so releasing reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc128s022_responder.sv
// SPI-slave model of the ADC128S022: shifts out channel samples chosen by the master's address bits.
// SCLK fall pin to adc_sdat change is SYNC_STAGES+1 clk; no flow control, master owns all timing.
module adc128s022_responder
    import adc_pkg::*;
#(
    parameter int CHANNELS    = ADC_CHANNELS,
    parameter int RES         = ADC_RES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    adc_cs_n,
    input  logic                    adc_sclk,
    input  logic                    adc_saddr,
    output logic                    adc_sdat,
    input  logic [CHANNELS*RES-1:0] ch_value,
    output logic                    frame_done,
    output logic [2:0]              frame_chan,
    output logic [2:0]              next_chan,
    output logic                    frame_abort
);

    localparam int         FB       = ADC_FRAME_BITS;
    localparam logic [4:0] CNT_LAST = 5'(ADC_FRAME_BITS);
    localparam logic [4:0] CNT_ADD2 = 5'(ADC_ADDR_LSB_CNT - 2);
    localparam logic [4:0] CNT_ADD1 = 5'(ADC_ADDR_LSB_CNT - 1);
    localparam logic [4:0] CNT_ADD0 = 5'(ADC_ADDR_LSB_CNT);

    logic cs_level_unused, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic saddr_level, saddr_rise_unused, saddr_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .n_reset(n_reset), .din(adc_cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .n_reset(n_reset), .din(adc_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_saddr (
        .clk(clk), .n_reset(n_reset), .din(adc_saddr),
        .level(saddr_level), .rise(saddr_rise_unused), .fall(saddr_fall_unused)
    );

    logic [RES-1:0] samples [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign samples[g] = ch_value[g*RES +: RES];
    end

    adc_resp_state_t state, state_nxt;
    logic [4:0]      bit_cnt, bit_cnt_nxt;
    logic [FB-1:0]   shift, shift_nxt;
    logic [2:0]      cur_chan, cur_chan_nxt;
    logic [2:0]      next_chan_nxt, frame_chan_nxt;
    logic            sdat_nxt, done_nxt, abort_nxt;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            cur_chan    <= '0;
            next_chan   <= '0;
            frame_chan  <= '0;
            adc_sdat    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            cur_chan    <= cur_chan_nxt;
            next_chan   <= next_chan_nxt;
            frame_chan  <= frame_chan_nxt;
            adc_sdat    <= sdat_nxt;
            frame_done  <= done_nxt;
            frame_abort <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        cur_chan_nxt   = cur_chan;
        next_chan_nxt  = next_chan;
        frame_chan_nxt = frame_chan;
        sdat_nxt       = adc_sdat;
        done_nxt       = 1'b0;
        abort_nxt      = 1'b0;

        case (state)
            IDLE: begin
                sdat_nxt = 1'b0;
                // The first conversion after CS falls is always IN0; any SCLK edge in this clk is dropped.
                if (cs_fall) begin
                    state_nxt    = ACTIVE;
                    bit_cnt_nxt  = '0;
                    cur_chan_nxt = '0;
                    shift_nxt    = {{(FB-RES){1'b0}}, samples[0]};
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    abort_nxt = (bit_cnt != '0);
                    sdat_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (sclk_rise) begin
                    if (bit_cnt < CNT_LAST) begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                    if (bit_cnt == CNT_ADD2) next_chan_nxt[2] = saddr_level;
                    if (bit_cnt == CNT_ADD1) next_chan_nxt[1] = saddr_level;
                    if (bit_cnt == CNT_ADD0) next_chan_nxt[0] = saddr_level;
                end else if (sclk_fall) begin
                    if (bit_cnt == CNT_LAST) begin
                        // This fall is also DB15 of a back-to-back frame, so reload here.
                        done_nxt       = 1'b1;
                        frame_chan_nxt = cur_chan;
                        cur_chan_nxt   = next_chan;
                        shift_nxt      = {{(FB-RES){1'b0}}, samples[next_chan]};
                        bit_cnt_nxt    = '0;
                        sdat_nxt       = 1'b0;
                    end else if (bit_cnt != '0) begin
                        shift_nxt = shift << 1;
                        sdat_nxt  = shift[FB-2];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_adc128s022_responder.sv
// Bench for adc128s022_responder: a bit-banged SPI master against a frame-level model
// (frame k returns the sample latched at its start, from the channel addressed in frame k-1, IN0 first).
module tb_adc128s022_responder;

    localparam int CH  = 8;
    localparam int RES = 12;

    logic              clk = 1'b0;
    logic              n_reset;
    logic              adc_cs_n;
    logic              adc_sclk;
    logic              adc_saddr;
    logic              adc_sdat;
    logic [CH*RES-1:0] ch_value;
    logic              frame_done;
    logic [2:0]        frame_chan;
    logic [2:0]        next_chan;
    logic              frame_abort;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    logic [2:0] mon_fchan = 3'd0;

    logic [7:0]        ctrl_w [16];
    logic [15:0]       rd_w   [16];
    logic [CH*RES-1:0] snap_w [16];

    adc128s022_responder #(.CHANNELS(CH), .RES(RES), .SYNC_STAGES(2)) dut (
        .clk(clk), .n_reset(n_reset), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
        .adc_saddr(adc_saddr), .adc_sdat(adc_sdat), .ch_value(ch_value),
        .frame_done(frame_done), .frame_chan(frame_chan), .next_chan(next_chan),
        .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            done_cnt++;
            mon_fchan = frame_chan;
        end
        if (frame_abort === 1'b1) abort_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [CH*RES-1:0] rand_vals();
        logic [CH*RES-1:0] v;
        for (int c = 0; c < CH; c++) v[c*RES +: RES] = 12'($urandom);
        return v;
    endfunction

    // Channel the model expects frame f of the last session to carry.
    function automatic int exp_chan(input int f);
        if (f == 0) return 0;
        return int'(ctrl_w[f-1][5:3]);
    endfunction

    function automatic logic [15:0] exp_word(input int f);
        logic [CH*RES-1:0] v;
        v = snap_w[f];
        return {4'b0000, v[exp_chan(f)*RES +: RES]};
    endfunction

    task automatic do_cycle(input int ph, input logic a, output logic s);
        adc_sclk  = 1'b0;
        adc_saddr = a;
        wait_clk(ph);
        s = adc_sdat;
        adc_sclk = 1'b1;
        wait_clk(ph);
    endtask

    task automatic end_session(input int ph);
        adc_sclk = 1'b0;
        wait_clk(ph);
        adc_cs_n = 1'b1;
        wait_clk(ph);
        adc_sclk = 1'b1;
        wait_clk(ph);
    endtask

    task automatic run_session(input int ph, input int nfr, input bit coincide, input bit mutate);
        logic s;
        if (coincide) begin
            adc_sclk = 1'b0;
            wait_clk(ph);
            adc_cs_n = 1'b0;
            adc_sclk = 1'b1;
        end else begin
            adc_cs_n = 1'b0;
        end
        wait_clk(ph);
        for (int f = 0; f < nfr; f++) begin
            snap_w[f] = ch_value;
            rd_w[f]   = '0;
            for (int b = 0; b < 16; b++) begin
                do_cycle(ph, (b < 8) ? ctrl_w[f][7-b] : 1'b0, s);
                rd_w[f] = {rd_w[f][14:0], s};
                if (mutate && b == 8) ch_value = rand_vals();
            end
        end
        end_session(ph);
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            adc_cs_n  = 1'($urandom_range(0, 1));
            adc_sclk  = 1'($urandom_range(0, 1));
            adc_saddr = 1'($urandom_range(0, 1));
            ch_value  = rand_vals();
            wait_clk(1);
            checks++;
            if (adc_sdat !== 1'b0 || frame_done !== 1'b0 || frame_abort !== 1'b0 ||
                frame_chan !== 3'd0 || next_chan !== 3'd0) begin
                errors++;
                $display("FAIL reset[%0d]: sdat=%b done=%b abort=%b fchan=%0d nchan=%0d, required all 0",
                         i, adc_sdat, frame_done, frame_abort, frame_chan, next_chan);
            end
        end
        adc_cs_n  = 1'b1;
        adc_sclk  = 1'b1;
        adc_saddr = 1'b0;
        wait_clk(3);
        n_reset = 1'b1;
        wait_clk(6);
        checks++;
        if (adc_sdat !== 1'b0 || done_cnt != 0 || abort_cnt != 0) begin
            errors++;
            $display("FAIL reset_release: sdat=%b done=%0d abort=%0d, required 0/0/0", adc_sdat, done_cnt, abort_cnt);
        end
    endtask

    task automatic test_single();
        int d0, a0;
        ch_value = rand_vals();
        ch_value[0 +: RES] = 12'hABC;
        ctrl_w[0] = 8'h28;
        d0 = done_cnt; a0 = abort_cnt;
        run_session(8, 1, 1'b0, 1'b0);
        checks++;
        if (rd_w[0] !== 16'h0ABC) begin
            errors++; $display("FAIL single_data: got %h, required 0abc", rd_w[0]);
        end
        checks++;
        if (done_cnt - d0 != 1 || abort_cnt != a0) begin
            errors++; $display("FAIL single_pulses: done=%0d abort=%0d, required 1/0", done_cnt - d0, abort_cnt - a0);
        end
        checks++;
        if (mon_fchan !== 3'd0 || next_chan !== 3'd5) begin
            errors++; $display("FAIL single_chan: fchan=%0d nchan=%0d, required 0/5", mon_fchan, next_chan);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        ch_value = rand_vals();
        ch_value[5*RES +: RES] = 12'h123;
        ctrl_w[0] = 8'h28;
        ctrl_w[1] = 8'h38;
        d0 = done_cnt;
        run_session(8, 2, 1'b0, 1'b0);
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (rd_w[f] !== exp_word(f)) begin
                errors++; $display("FAIL b2b_data[%0d]: got %h, required %h", f, rd_w[f], exp_word(f));
            end
        end
        checks++;
        if (rd_w[1] !== 16'h0123) begin
            errors++; $display("FAIL b2b_ch5: got %h, required 0123", rd_w[1]);
        end
        checks++;
        if (done_cnt - d0 != 2 || mon_fchan !== 3'd5 || next_chan !== 3'd7) begin
            errors++;
            $display("FAIL b2b_chan: done=%0d fchan=%0d nchan=%0d, required 2/5/7", done_cnt - d0, mon_fchan, next_chan);
        end
    endtask

    task automatic test_abort();
        int d0, a0;
        logic s;
        ch_value = rand_vals();
        ch_value[7] = 1'b1;
        ctrl_w[0] = 8'h30 | 8'($urandom_range(0, 7));
        d0 = done_cnt; a0 = abort_cnt;
        adc_cs_n = 1'b0;
        wait_clk(8);
        for (int b = 0; b < 9; b++) do_cycle(8, ctrl_w[0][7-b], s);
        adc_cs_n = 1'b1;
        wait_clk(8);
        checks++;
        if (abort_cnt - a0 != 1 || done_cnt != d0) begin
            errors++; $display("FAIL abort_pulses: abort=%0d done=%0d, required 1/0", abort_cnt - a0, done_cnt - d0);
        end
        checks++;
        if (adc_sdat !== 1'b0) begin
            errors++; $display("FAIL abort_sdat: got %b, required 0", adc_sdat);
        end
        ctrl_w[0] = 8'($urandom);
        d0 = done_cnt;
        run_session(8, 1, 1'b0, 1'b0);
        checks++;
        if (rd_w[0] !== exp_word(0) || mon_fchan !== 3'd0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL abort_reentry: got %h fchan=%0d done=%0d, required %h/0/1", rd_w[0], mon_fchan, done_cnt - d0, exp_word(0));
        end
    endtask

    task automatic test_coincide();
        int d0, a0;
        ch_value = rand_vals();
        ctrl_w[0] = 8'($urandom);
        ctrl_w[1] = 8'($urandom);
        d0 = done_cnt; a0 = abort_cnt;
        run_session(8, 2, 1'b1, 1'b0);
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (rd_w[f] !== exp_word(f)) begin
                errors++; $display("FAIL coincide_data[%0d]: got %h, required %h", f, rd_w[f], exp_word(f));
            end
        end
        checks++;
        if (done_cnt - d0 != 2 || abort_cnt != a0) begin
            errors++; $display("FAIL coincide_pulses: done=%0d abort=%0d, required 2/0", done_cnt - d0, abort_cnt - a0);
        end
    endtask

    task automatic test_latency();
        logic s;
        ch_value = rand_vals();
        ch_value[0 +: RES] = 12'h800;
        adc_cs_n = 1'b0;
        wait_clk(8);
        for (int b = 0; b < 4; b++) do_cycle(8, 1'b0, s);
        adc_sclk = 1'b0;
        wait_clk(2);
        checks++;
        if (adc_sdat !== 1'b0) begin
            errors++; $display("FAIL latency_early: sdat=%b 2 clk after fall, required 0", adc_sdat);
        end
        wait_clk(1);
        checks++;
        if (adc_sdat !== 1'b1) begin
            errors++; $display("FAIL latency_on_time: sdat=%b 3 clk after fall, required 1", adc_sdat);
        end
        wait_clk(5);
        adc_sclk = 1'b1;
        wait_clk(8);
        for (int b = 0; b < 11; b++) do_cycle(8, 1'b0, s);
        end_session(8);
    endtask

    task automatic test_reset_midframe();
        int a0;
        logic s;
        ch_value = rand_vals();
        ch_value[10] = 1'b1;
        a0 = abort_cnt;
        adc_cs_n = 1'b0;
        wait_clk(8);
        for (int b = 0; b < 6; b++) do_cycle(8, 1'b1, s);
        checks++;
        if (next_chan !== 3'd7) begin
            errors++; $display("FAIL midreset_pre: nchan=%0d, required 7", next_chan);
        end
        n_reset  = 1'b0;
        adc_cs_n = 1'b1;
        adc_sclk = 1'b1;
        wait_clk(1);
        checks++;
        if (next_chan !== 3'd0 || adc_sdat !== 1'b0 || frame_chan !== 3'd0) begin
            errors++;
            $display("FAIL midreset_vals: nchan=%0d sdat=%b fchan=%0d, required 0/0/0", next_chan, adc_sdat, frame_chan);
        end
        wait_clk(3);
        n_reset = 1'b1;
        wait_clk(6);
        ctrl_w[0] = 8'($urandom);
        run_session(8, 1, 1'b0, 1'b0);
        checks++;
        if (rd_w[0] !== exp_word(0) || abort_cnt != a0) begin
            errors++; $display("FAIL midreset_after: got %h abort=%0d, required %h/0", rd_w[0], abort_cnt - a0, exp_word(0));
        end
    endtask

    task automatic test_min_timing();
        int d0;
        ch_value = rand_vals();
        for (int f = 0; f < 8; f++) begin
            ctrl_w[f] = 8'($urandom);
            ctrl_w[f][5:3] = 3'((f + 1) % 8);
        end
        d0 = done_cnt;
        run_session(4, 8, 1'b0, 1'b1);
        for (int f = 0; f < 8; f++) begin
            checks++;
            if (rd_w[f] !== exp_word(f)) begin
                errors++;
                $display("FAIL min_timing[%0d] ch%0d: got %h, required %h", f, exp_chan(f), rd_w[f], exp_word(f));
            end
        end
        checks++;
        if (done_cnt - d0 != 8 || mon_fchan !== 3'd7 || next_chan !== 3'd0) begin
            errors++;
            $display("FAIL min_timing_chan: done=%0d fchan=%0d nchan=%0d, required 8/7/0", done_cnt - d0, mon_fchan, next_chan);
        end
    endtask

    initial begin
        n_reset   = 1'b0;
        adc_cs_n  = 1'b1;
        adc_sclk  = 1'b1;
        adc_saddr = 1'b0;
        ch_value  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_coincide();
        test_latency();
        test_reset_midframe();
        test_min_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
